// File: rtl/arm_fetch_pkg.sv
// ---------------------------------------------------------------------------
// arm_fetch_pkg
// Shared types and helpers for the instruction-fetch stage.
//   fetch_state_t  : fetch sequencer states (RUN, DRAIN, HALT)
//   if_id_t        : IF/ID pipeline register contents
//   HALT_WORD_DEFAULT : encoding of "B #-1", the program-terminating branch
//   align_word()   : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package arm_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] HALT_WORD_DEFAULT = 32'hEAFF_FFFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // An all-zero value is the bubble.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
    logic            valid;
  } if_id_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_register.sv
// ---------------------------------------------------------------------------
// pc_register
// N-bit program-counter register with load enable.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset, loads RESET_PC
//   i_load : capture i_d on the next rising edge
//   i_d    : next PC value
//   o_q    : current PC value
// ---------------------------------------------------------------------------
module pc_register #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RESET_PC;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
// Instruction-fetch sequencer: owns the PC, addresses the combinational
// instruction memory, loads the IF/ID register, and handles freeze, branch
// redirect and the self-branch that terminates a program.
//   clk, rst        : clock, asynchronous active-high reset
//   freeze          : hazard stall, hold PC and IF/ID
//   branch_taken    : taken branch resolved in EX this cycle
//   branch_addr     : branch target (bits [1:0] ignored)
//   imem_addr       : instruction memory address (= PC)
//   imem_data       : instruction word at imem_addr
//   if_pc           : IF/ID fetch address + 4
//   if_instruction  : IF/ID instruction word
//   if_valid        : IF/ID holds a real instruction
//   halted          : fetch permanently stopped
//   fetch_count     : number of valid words loaded into IF/ID
// N must equal arm_fetch_pkg::XLEN.
// ---------------------------------------------------------------------------
module fetch_controller
  import arm_fetch_pkg::*;
#(
  parameter int           N         = 32,
  parameter logic [N-1:0] RESET_PC  = '0,
  parameter logic [N-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_addr,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_data,
  output logic [N-1:0] if_pc,
  output logic [N-1:0] if_instruction,
  output logic         if_valid,
  output logic         halted,
  output logic [N-1:0] fetch_count
);

  fetch_state_t r_state;
  if_id_t       r_if_id;
  logic [N-1:0] r_halt_pc;
  logic [N-1:0] r_fetch_count;
  logic         r_halted;

  logic [N-1:0] w_pc;
  logic [N-1:0] w_pc_plus4;
  logic [N-1:0] w_pc_next;
  logic [N-1:0] w_target;
  logic         w_pc_load;
  logic         w_hits_halt;

  assign w_pc_plus4  = w_pc + N'(4);
  assign w_target    = align_word(branch_addr);
  // The halt self-branch resolving in EX confirms the speculative halt.
  assign w_hits_halt = (w_target == r_halt_pc);

  // NOTE: both outputs get a default before the case so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    w_pc_load = 1'b0;
    w_pc_next = w_pc_plus4;
    case (r_state)
      RUN: begin
        if (branch_taken) begin
          w_pc_load = 1'b1;
          w_pc_next = w_target;
        end else if (!freeze) begin
          w_pc_load = 1'b1;
        end
      end
      // PC already sits at halt_pc+4; only a cancelling branch moves it.
      DRAIN: begin
        if (branch_taken && !w_hits_halt) begin
          w_pc_load = 1'b1;
          w_pc_next = w_target;
        end
      end
      default: begin
        w_pc_load = 1'b0;
      end
    endcase
  end

  pc_register #(
    .N        (N),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_pc_load),
    .i_d    (w_pc_next),
    .o_q    (w_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_if_id       <= '0;
      r_halt_pc     <= '0;
      r_fetch_count <= '0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (branch_taken) begin
            r_if_id <= '0;
          end else if (!freeze) begin
            r_if_id       <= '{pc: w_pc_plus4, instruction: imem_data, valid: 1'b1};
            r_fetch_count <= r_fetch_count + N'(1);
            if (imem_data == HALT_WORD) begin
              r_halt_pc <= w_pc;
              r_state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (branch_taken) begin
            r_if_id  <= '0;
            r_state  <= w_hits_halt ? HALT : RUN;
            r_halted <= w_hits_halt;
          end else if (!freeze) begin
            r_if_id <= '0;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign imem_addr      = w_pc;
  assign if_pc          = r_if_id.pc;
  assign if_instruction = r_if_id.instruction;
  assign if_valid       = r_if_id.valid;
  assign halted         = r_halted;
  assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  localparam logic [31:0] HALT = 32'hEAFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  logic [31:0] rom [256];

  fetch_controller dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .if_valid       (if_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr[9:2]];

  // Test ROM: word 0 is "mov r0,#20", word 46 (address 184) is the halt branch.
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hE280_0000 + 32'(i);
    rom[0]  = 32'hE3A0_0014;
    rom[46] = HALT;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks what fetch should have done, not how.
  logic [31:0] m_pc, m_if_pc, m_if_instr, m_count, m_halt_pc;
  logic        m_if_valid;
  bit          m_waiting_halt, m_stopped;

  always @(posedge clk or posedge rst) begin
    logic [31:0] tgt, word;
    if (rst) begin
      m_pc = 32'd0; m_if_pc = 32'd0; m_if_instr = 32'd0; m_if_valid = 1'b0;
      m_count = 32'd0; m_halt_pc = 32'd0; m_waiting_halt = 1'b0; m_stopped = 1'b0;
    end else if (!m_stopped) begin
      tgt = branch_addr & ~32'd3;
      if (branch_taken) begin
        m_if_pc = 32'd0; m_if_instr = 32'd0; m_if_valid = 1'b0;
        if (m_waiting_halt && tgt == m_halt_pc) m_stopped = 1'b1;
        else m_pc = tgt;
        m_waiting_halt = 1'b0;
      end else if (!freeze) begin
        if (m_waiting_halt) begin
          m_if_pc = 32'd0; m_if_instr = 32'd0; m_if_valid = 1'b0;
        end else begin
          word = rom[m_pc[9:2]];
          m_if_pc = m_pc + 32'd4; m_if_instr = word; m_if_valid = 1'b1;
          m_count = m_count + 32'd1;
          if (word == HALT) begin
            m_halt_pc = m_pc;
            m_waiting_halt = 1'b1;
          end
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("model imem_addr", imem_addr, m_pc);
      check("model if_pc", if_pc, m_if_pc);
      check("model if_instruction", if_instruction, m_if_instr);
      check("model if_valid", 32'(if_valid), 32'(m_if_valid));
      check("model halted", 32'(halted), 32'(m_stopped));
      check("model fetch_count", fetch_count, m_count);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " imem_addr"}, imem_addr, 32'd0);
    check({tag, " if_pc"}, if_pc, 32'd0);
    check({tag, " if_instruction"}, if_instruction, 32'd0);
    check({tag, " if_valid"}, 32'(if_valid), 32'd0);
    check({tag, " halted"}, 32'(halted), 32'd0);
    check({tag, " fetch_count"}, fetch_count, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved_count;
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
    tick();
    check_reset_values("reset");
    #2 rst = 1'b0;
    cmp_en = 1'b1;

    // Free run from address 0.
    tick();
    check("run imem_addr", imem_addr, 32'd4);
    check("run first instr", if_instruction, 32'hE3A0_0014);
    check("run first if_pc", if_pc, 32'd4);
    tick();
    check("run imem_addr 2", imem_addr, 32'd8);
    check("run second if_pc", if_pc, 32'd8);
    check("run second instr", if_instruction, 32'hE280_0001);
    check("run fetch_count", fetch_count, 32'd2);
    tick();
    check("run imem_addr 3", imem_addr, 32'd12);

    // Freeze for three cycles at pc=12.
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze imem_addr", imem_addr, 32'd12);
      check("freeze instr", if_instruction, 32'hE280_0002);
      check("freeze count", fetch_count, 32'd3);
    end
    freeze = 1'b0;
    tick();
    check("resume if_pc", if_pc, 32'd16);
    check("resume count", fetch_count, 32'd4);

    // Branch overrides freeze.
    branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'd112;
    tick();
    branch_taken = 1'b0; freeze = 1'b0;
    check("branch imem_addr", imem_addr, 32'd112);
    check("branch bubble", 32'(if_valid), 32'd0);
    tick();
    check("branch target if_pc", if_pc, 32'd116);
    check("branch target instr", if_instruction, 32'hE280_001C);

    // Misaligned target.
    branch_taken = 1'b1; branch_addr = 32'h73;
    tick();
    branch_taken = 1'b0;
    check("misaligned imem_addr", imem_addr, 32'h70);

    // Halt word at 184, confirmed by the self-branch.
    branch_taken = 1'b1; branch_addr = 32'd184;
    tick();
    branch_taken = 1'b0;
    check("to halt imem_addr", imem_addr, 32'd184);
    tick();
    check("halt word fetched", if_instruction, HALT);
    check("drain imem_addr", imem_addr, 32'd188);
    saved_count = fetch_count;
    freeze = 1'b1;
    tick();
    check("drain freeze holds", 32'(if_valid), 32'd1);
    freeze = 1'b0;
    tick();
    check("drain bubble", 32'(if_valid), 32'd0);
    check("drain imem_addr held", imem_addr, 32'd188);
    branch_taken = 1'b1; branch_addr = 32'd184;
    tick();
    branch_taken = 1'b0;
    check("halted set", 32'(halted), 32'd1);
    repeat (3) tick();
    check("halted imem_addr", imem_addr, 32'd188);
    check("halted count", fetch_count, saved_count);
    branch_taken = 1'b1; branch_addr = 32'd0; freeze = 1'b1;
    tick();
    branch_taken = 1'b0; freeze = 1'b0;
    check("halted ignores branch", imem_addr, 32'd188);
    check("halted sticky", 32'(halted), 32'd1);

    // Reset out of HALT, then cancel a speculative halt.
    rst = 1'b1;
    #2 rst = 1'b0;
    branch_taken = 1'b1; branch_addr = 32'd184;
    tick();
    branch_taken = 1'b0;
    tick();
    check("second drain imem_addr", imem_addr, 32'd188);
    branch_taken = 1'b1; branch_addr = 32'd100;
    tick();
    branch_taken = 1'b0;
    check("cancel imem_addr", imem_addr, 32'd100);
    check("cancel halted", 32'(halted), 32'd0);
    check("cancel bubble", 32'(if_valid), 32'd0);
    tick();
    check("cancel resume if_pc", if_pc, 32'd104);

    // Asynchronous reset in the middle of DRAIN.
    branch_taken = 1'b1; branch_addr = 32'd184;
    tick();
    branch_taken = 1'b0;
    tick();
    check("third drain if_valid", 32'(if_valid), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_values("async reset");
    #1 rst = 1'b0;
    tick();
    check("after reset imem_addr", imem_addr, 32'd4);
    check("after reset instr", if_instruction, 32'hE3A0_0014);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
